// File: rtl/stoch_result_receiver.sv
// Receives three LSB-first 10-bit serial result frames in lockstep and presents a tuple once it
// has been seen CONFIRM times in a row, with a valid/ready handshake and sticky error flags.
module stoch_result_receiver #(
  parameter int unsigned CONFIRM = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ser_in,
  input  logic       frame_sync,
  input  logic       out_ready,
  input  logic       clr_flags,
  output logic [8:0] mul_val,
  output logic [8:0] add_val,
  output logic [8:0] smul_val,
  output logic       out_valid,
  output logic       overflow,
  output logic       frame_err
);

  typedef enum logic {StHunt, StRecv} state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [2:0]  match_q;
  logic [8:0]  mul_sr_q, add_sr_q, smul_sr_q;
  logic [26:0] prev_q, pres_q;
  logic        presented_q;

  logic [26:0] frame_tuple;
  logic        stop_cycle, stop_bad, good_frame, eligible;
  logic        ferr_set, ovf_set;
  logic [2:0]  match_next;

  always_comb begin
    frame_tuple = {smul_sr_q, add_sr_q, mul_sr_q};
    // A sync pulse at index 9 is a resync, so it is not a stop-bit cycle.
    stop_cycle  = (state_q == StRecv) && (idx_q == 4'd9) && !frame_sync;
    stop_bad    = |ser_in;
    good_frame  = stop_cycle && !stop_bad;
    if (frame_tuple == prev_q) begin
      match_next = (match_q == 3'd7) ? 3'd7 : match_q + 3'd1;
    end else begin
      match_next = 3'd1;
    end
    eligible = good_frame && (match_next == 3'(CONFIRM)) &&
               (!presented_q || (frame_tuple != pres_q));
    ferr_set = stop_cycle && stop_bad;
    ovf_set  = eligible && out_valid && !out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      idx_q       <= 4'd0;
      match_q     <= 3'd0;
      mul_sr_q    <= 9'd0;
      add_sr_q    <= 9'd0;
      smul_sr_q   <= 9'd0;
      prev_q      <= 27'd0;
      pres_q      <= 27'd0;
      presented_q <= 1'b0;
      mul_val     <= 9'd0;
      add_val     <= 9'd0;
      smul_val    <= 9'd0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (frame_sync) begin
            mul_sr_q[0]  <= ser_in[0];
            add_sr_q[0]  <= ser_in[1];
            smul_sr_q[0] <= ser_in[2];
            idx_q        <= 4'd1;
            state_q      <= StRecv;
          end
        end
        StRecv: begin
          if (frame_sync || (idx_q == 4'd0)) begin
            mul_sr_q[0]  <= ser_in[0];
            add_sr_q[0]  <= ser_in[1];
            smul_sr_q[0] <= ser_in[2];
            idx_q        <= 4'd1;
          end else if (idx_q == 4'd9) begin
            idx_q <= 4'd0;
            if (stop_bad) begin
              match_q <= 3'd0;
            end else begin
              match_q <= match_next;
              prev_q  <= frame_tuple;
            end
          end else begin
            mul_sr_q[idx_q]  <= ser_in[0];
            add_sr_q[idx_q]  <= ser_in[1];
            smul_sr_q[idx_q] <= ser_in[2];
            idx_q            <= idx_q + 4'd1;
          end
        end
        default: state_q <= StHunt;
      endcase

      if (eligible) begin
        mul_val     <= mul_sr_q;
        add_val     <= add_sr_q;
        smul_val    <= smul_sr_q;
        out_valid   <= 1'b1;
        pres_q      <= frame_tuple;
        presented_q <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Setting events win over a simultaneous clear.
      overflow  <= ovf_set  | (overflow  & ~clr_flags);
      frame_err <= ferr_set | (frame_err & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_stoch_result_receiver.sv
// Table-driven bench for stoch_result_receiver (CONFIRM=2): frame rows push expected output state
// to a scoreboard queue that is popped after each stop-bit edge; hand sequences cover resync/reset.
module tb_stoch_result_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ser_in;
  logic       frame_sync, out_ready, clr_flags;
  logic [8:0] mul_val, add_val, smul_val;
  logic       out_valid, overflow, frame_err;

  int errors = 0;
  int checks = 0;

  stoch_result_receiver #(.CONFIRM(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .frame_sync(frame_sync),
    .out_ready (out_ready),
    .clr_flags (clr_flags),
    .mul_val   (mul_val),
    .add_val   (add_val),
    .smul_val  (smul_val),
    .out_valid (out_valid),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] m, a, s;
    logic [2:0] stop;
    logic       rdy, clr;
    logic       ev;
    logic [8:0] em, ea, es;
    logic       eo, ef;
  } vec_t;

  typedef struct {
    logic       v;
    logic [8:0] m, a, s;
    logic       o, f;
  } exp_t;

  localparam int NVec = 19;
  vec_t tbl[NVec];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " out_valid"}, int'(out_valid), int'(e.v));
    chk({tag, " mul_val"},   int'(mul_val),   int'(e.m));
    chk({tag, " add_val"},   int'(add_val),   int'(e.a));
    chk({tag, " smul_val"},  int'(smul_val),  int'(e.s));
    chk({tag, " overflow"},  int'(overflow),  int'(e.o));
    chk({tag, " frame_err"}, int'(frame_err), int'(e.f));
  endtask

  // Drives one input cycle; returns #1 after the sampling edge.
  task automatic drive(input logic [2:0] d, input logic sync, input logic rdy, input logic clr);
    ser_in     = d;
    frame_sync = sync;
    out_ready  = rdy;
    clr_flags  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s,
                            input logic [2:0] stop, input logic rdy, input logic clr);
    for (int i = 0; i < 9; i++) drive({s[i], a[i], m[i]}, (i == 0), 1'b0, 1'b0);
    drive(stop, 1'b0, rdy, clr);
    drive(3'b000, 1'b0, 1'b0, 1'b0);  // idx 0 idle cycle; next frame's sync resyncs at idx 1
  endtask

  function automatic exp_t mk_exp(input logic v, input logic [8:0] m, input logic [8:0] a,
                                  input logic [8:0] s, input logic o, input logic f);
    exp_t e;
    e.v = v; e.m = m; e.a = a; e.s = s; e.o = o; e.f = f;
    return e;
  endfunction

  initial begin
    exp_t e;
    //          m       a       s       stop    rdy   clr   ev    em      ea      es      eo    ef
    tbl[0]  = '{9'h0A5, 9'h100, 9'h1FF, 3'b000, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0};
    tbl[1]  = '{9'h0A5, 9'h100, 9'h1FF, 3'b000, 1'b0, 1'b0, 1'b1, 9'h0A5, 9'h100, 9'h1FF, 1'b0, 1'b0};
    tbl[2]  = '{9'h0A5, 9'h100, 9'h1FF, 3'b000, 1'b0, 1'b0, 1'b1, 9'h0A5, 9'h100, 9'h1FF, 1'b0, 1'b0};
    tbl[3]  = '{9'h0A5, 9'h100, 9'h1FF, 3'b000, 1'b1, 1'b0, 1'b0, 9'h0A5, 9'h100, 9'h1FF, 1'b0, 1'b0};
    tbl[4]  = '{9'h003, 9'h003, 9'h003, 3'b000, 1'b0, 1'b0, 1'b0, 9'h0A5, 9'h100, 9'h1FF, 1'b0, 1'b0};
    tbl[5]  = '{9'h004, 9'h004, 9'h004, 3'b000, 1'b0, 1'b0, 1'b0, 9'h0A5, 9'h100, 9'h1FF, 1'b0, 1'b0};
    tbl[6]  = '{9'h004, 9'h004, 9'h004, 3'b000, 1'b0, 1'b0, 1'b1, 9'h004, 9'h004, 9'h004, 1'b0, 1'b0};
    tbl[7]  = '{9'h011, 9'h011, 9'h011, 3'b000, 1'b0, 1'b0, 1'b1, 9'h004, 9'h004, 9'h004, 1'b0, 1'b0};
    tbl[8]  = '{9'h011, 9'h011, 9'h011, 3'b000, 1'b0, 1'b0, 1'b1, 9'h011, 9'h011, 9'h011, 1'b1, 1'b0};
    tbl[9]  = '{9'h022, 9'h022, 9'h022, 3'b000, 1'b0, 1'b1, 1'b1, 9'h011, 9'h011, 9'h011, 1'b0, 1'b0};
    tbl[10] = '{9'h022, 9'h022, 9'h022, 3'b000, 1'b0, 1'b0, 1'b1, 9'h022, 9'h022, 9'h022, 1'b1, 1'b0};
    tbl[11] = '{9'h033, 9'h033, 9'h033, 3'b000, 1'b0, 1'b1, 1'b1, 9'h022, 9'h022, 9'h022, 1'b0, 1'b0};
    tbl[12] = '{9'h033, 9'h033, 9'h033, 3'b000, 1'b1, 1'b0, 1'b1, 9'h033, 9'h033, 9'h033, 1'b0, 1'b0};
    tbl[13] = '{9'h044, 9'h044, 9'h044, 3'b000, 1'b1, 1'b0, 1'b0, 9'h033, 9'h033, 9'h033, 1'b0, 1'b0};
    tbl[14] = '{9'h044, 9'h044, 9'h044, 3'b100, 1'b0, 1'b0, 1'b0, 9'h033, 9'h033, 9'h033, 1'b0, 1'b1};
    tbl[15] = '{9'h044, 9'h044, 9'h044, 3'b000, 1'b0, 1'b0, 1'b0, 9'h033, 9'h033, 9'h033, 1'b0, 1'b1};
    tbl[16] = '{9'h044, 9'h044, 9'h044, 3'b000, 1'b0, 1'b0, 1'b1, 9'h044, 9'h044, 9'h044, 1'b0, 1'b1};
    tbl[17] = '{9'h055, 9'h055, 9'h055, 3'b000, 1'b0, 1'b1, 1'b1, 9'h044, 9'h044, 9'h044, 1'b0, 1'b0};
    tbl[18] = '{9'h055, 9'h055, 9'h055, 3'b001, 1'b0, 1'b1, 1'b1, 9'h044, 9'h044, 9'h044, 1'b0, 1'b1};

    rst_n = 1'b0;
    ser_in = 3'b000; frame_sync = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk_exp(1'b0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0));
    rst_n = 1'b1;

    for (int r = 0; r < NVec; r++) begin
      sb.push_back(mk_exp(tbl[r].ev, tbl[r].em, tbl[r].ea, tbl[r].es, tbl[r].eo, tbl[r].ef));
      send_frame(tbl[r].m, tbl[r].a, tbl[r].s, tbl[r].stop, tbl[r].rdy, tbl[r].clr);
      e = sb.pop_front();
      check_out($sformatf("row%0d", r), e);
    end

    // One-cycle accept with no new frame: valid drops, data and sticky flag hold.
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    check_out("accept", mk_exp(1'b0, 9'h044, 9'h044, 9'h044, 1'b0, 1'b1));

    // Partial frame cut off by a sync pulse at index 5, then an aligned pair.
    for (int i = 0; i < 5; i++) drive({3{i[0]}} ^ 3'b101, (i == 0), 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 9'h066, 9'h099, 9'h1AB, 1'b0, 1'b1));
    send_frame(9'h066, 9'h099, 9'h1AB, 3'b000, 1'b0, 1'b0);
    send_frame(9'h066, 9'h099, 9'h1AB, 3'b000, 1'b0, 1'b0);
    e = sb.pop_front();
    check_out("resync", e);

    // Reset at index 4 with other controls asserted, then garbage while hunting.
    for (int i = 0; i < 4; i++) drive(3'b111, (i == 0), 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(3'b111, 1'b1, 1'b1, 1'b1);
    check_out("midreset", mk_exp(1'b0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0));
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) drive(3'b111, 1'b0, 1'b0, 1'b0);
    check_out("hunt", mk_exp(1'b0, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0));
    sb.push_back(mk_exp(1'b1, 9'h077, 9'h123, 9'h0F0, 1'b0, 1'b0));
    send_frame(9'h077, 9'h123, 9'h0F0, 3'b000, 1'b0, 1'b0);
    send_frame(9'h077, 9'h123, 9'h0F0, 3'b000, 1'b0, 1'b0);
    e = sb.pop_front();
    check_out("postreset", e);

    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stoch_result_receiver.md
STOCH_RESULT_RECEIVER -- requirements
Module: stoch_result_receiver

Interface
REQ-001 SHALL have parameter CONFIRM, default 2, meaning the number of consecutive identical frames (range 1..7) required before a result is presented.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port ser_in  input  3  serial result lines: [0] multiplier, [1] adder, [2] self-multiplier; one bit per clk.
REQ-005 SHALL have port frame_sync  input  1  high marks the current cycle as bit 0 of a frame on all three lines.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the presented result.
REQ-007 SHALL have port clr_flags  input  1  clears the sticky flags.
REQ-008 SHALL have port mul_val, add_val, smul_val  output  9 each  presented result values.
REQ-009 SHALL have port out_valid  output  1  presented result is valid.
REQ-010 SHALL have port overflow  output  1  sticky flag: an unaccepted result was overwritten.
REQ-011 SHALL have port frame_err  output  1  sticky flag: a stop bit was 1.

Function
REQ-012 SHALL decode 10-bit frames: cycles 0..8 carry value bits [0]..[8] (LSB first); cycle 9 carries the stop bit, which must be 0.
REQ-013 SHALL implement states HUNT and RECV; a 4-bit index counts 0..9 while in RECV.
REQ-014 HUNT: with frame_sync=1, SHALL sample bit 0, set index=1, and go to RECV; with frame_sync=0, SHALL stay in HUNT and discard ser_in.
REQ-015 RECV: SHALL sample bit[index] on each lane and increment index; at index 9 SHALL sample the stop bit, set index=0, and stay in RECV, so the next cycle is bit 0.
REQ-016 RECV: frame_sync=1 at index != 0 SHALL discard the partial frame, treat the cycle as bit 0, and set index=1 (resync); the match count is unaffected.
REQ-017 Stop bit = 1 on any lane SHALL discard the frame on all lanes, set frame_err, and reset the match count to 0.
REQ-018 On a good frame, SHALL compare the 27-bit tuple with the previous good frame: if equal, match count saturating-increments; otherwise match count = 1 and previous = new tuple.
REQ-019 A result SHALL be eligible when match count reaches CONFIRM on this frame and the tuple differs from the last presented tuple, or nothing has been presented since reset.
REQ-020 An eligible result SHALL load mul_val/add_val/smul_val and set out_valid on the same edge that samples the stop bit.
REQ-021 Handshake: out_valid && out_ready on an edge SHALL clear out_valid, unless a new eligible result loads on that edge; in that case out_valid stays 1 with the new data and overflow is not set.
REQ-022 An eligible load while out_valid=1 and out_ready=0 SHALL overwrite the data, keep out_valid=1, and set overflow.
REQ-023 Data outputs SHALL remain stable while out_valid=1, except on the loads defined in REQ-020..022.
REQ-024 clr_flags=1 SHALL clear overflow and frame_err on that edge; a flag-setting event on the same edge SHALL take priority, leaving the flag set.
REQ-025 CONFIRM=1 SHALL present every good frame whose tuple differs from the last presented tuple.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force: state HUNT, index 0, match count 0, previous/presented tuples cleared, "presented" marker cleared, all value outputs 0, out_valid 0, overflow 0, frame_err 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; reception resumes only at the next frame_sync=1 after rst_n=1.
REQ-028 rst_n SHALL override clr_flags, out_ready and frame_sync.

Verification
REQ-029 Two consecutive frames, mul=9'h0A5, add=9'h100, smul=9'h1FF, stop bits 0, out_ready=0 -> out_valid=1 on the second stop-bit edge with those values; no flags set.
REQ-030 A third identical frame after REQ-029 -> no reload, no overflow; then out_ready=1 for one cycle -> out_valid=0.
REQ-031 Frame 1 = 9'h003, frame 2 = 9'h004, frame 3 = 9'h004 on all lanes -> out_valid rises only at the frame-3 stop bit, presenting 9'h004.
REQ-032 Stop bit = 1 on lane 2 in frame 2 of an otherwise identical pair -> frame_err=1, out_valid stays 0; two further good frames -> out_valid=1; clr_flags -> frame_err=0.
REQ-033 Presented 9'h011 unaccepted, then two frames of 9'h022 -> values become 9'h022, out_valid=1, overflow=1; repeat with out_ready=1 on the load edge -> overflow stays 0.
REQ-034 frame_sync pulsed at index 5, or rst_n=0 at index 4 -> partial frame discarded; a subsequent aligned pair presents the correct values.
